multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Multicycle main control FSM for the MIPS-subset CPU.
- Sequences one shared ALU, memory and register file over several cycles per instruction.
- Generates the 2-bit ALUOp consumed by the ALU control decoder (00 add, 01 subtract, 10 use funct) plus all datapath mux and enable strobes.
- Sits between the instruction register opcode field and the datapath; waits on a memory-ready handshake.

Parameters:
- INSTR_CNT_W, 16, width of the retired-instruction counter (wraps modulo 2^INSTR_CNT_W).

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable from the cycle after FETCH completes until the next FETCH
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (branch)
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write data: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  destination register: 1 = rd, 0 = rt
- reg_write  out  1  register file write
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B operand: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
- alu_op  out  2  to ALU control: 00 add, 01 sub, 10 funct
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- illegal  out  1  sticky illegal-opcode flag
- instr_retired  out  INSTR_CNT_W  count of completed instructions
- state_dbg  out  4  current state encoding

Behaviour:
- Reset (async, reset_n=0):
  - state = IDLE; instr_retired = 0; illegal = 0.
  - All strobes are 0; alu_op = 00; alu_src_b = 00; pc_source = 00.
  - Reset asserted mid-instruction aborts it immediately, with no write strobes in that cycle.
- Outputs are Moore-decoded from the state register, except ir_write and pc_write in FETCH, which equal mem_ready.
- IDLE: all outputs 0; go to FETCH on the next clock.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Hold while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch on opcode:
  - 0x23 or 0x2B → MEM_ADDR
  - 0x00 → R_EXEC
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - any other opcode → ILLEGAL
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_READ for 0x23, MEM_WRITE for 0x2B.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Go to FETCH.
- JUMP: pc_write=1, pc_source=10. Go to FETCH.
- ILLEGAL: all strobes 0; illegal is set and held. No exit except reset.
- instr_retired increments by 1 on each transition from MEM_WB, MEM_WRITE (with mem_ready), R_WB, BRANCH or JUMP into FETCH. It wraps at 2^INSTR_CNT_W - 1 → 0.
- Cycle counts with zero memory wait: lw 5, sw 4, R-type 4, beq 3, j 3. Each mem_ready=0 cycle adds one.
- mem_ready is ignored in states that make no memory request.
- Unreachable state encodings go to IDLE.

Optional Feature:
- Macro ADDI_EN.
- When defined:
  - DECODE dispatches opcode 0x08 to ADDI_EXEC.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDI_WB.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH, counted as retired. addi takes 4 cycles.
- When undefined: 0x08 goes to ILLEGAL; ADDI states are not synthesized.

Decomposition:
- Shared package ctrl_pkg holds:
  - State encodings (4-bit).
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - ALUOp constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - alu_src_b and pc_source encodings.
- One natural sub-module: ctrl_out_decode, the combinational state-to-strobes decoder. The top keeps the state register, next-state logic, counter and illegal flag.

Test Plan:
- Reset: hold reset_n=0 with mem_ready=1 → all strobes 0, state_dbg=IDLE, instr_retired=0. Release → IDLE for 1 cycle, then FETCH with mem_read=1, alu_src_b=01.
- lw (opcode 0x23) with mem_ready low 2 cycles in FETCH and 1 in MEM_READ → 8 cycles total; reg_write=1 with mem_to_reg=1 only in MEM_WB; instr_retired=1.
- R-type (0x00), mem_ready=1 → R_EXEC shows alu_op=10, alu_src_a=1; R_WB shows reg_dst=1; 4 cycles; then beq (0x04) → BRANCH shows alu_op=01, pc_write_cond=1, pc_source=01.
- Illegal opcode 0x3F → ILLEGAL after DECODE; illegal=1 held 20 cycles with no strobes; reset_n pulse clears it.
- INSTR_CNT_W=2, five j (0x02) instructions → pc_source=10 each time; instr_retired sequence 1,2,3,0,1.
- Reset asserted in MEM_WRITE while mem_ready=0 → mem_write drops immediately, no retire. With ADDI_EN, 0x08 retires in 4 cycles; without it, 0x08 → illegal=1.

Source files
------------

// File: rtl/multicycle_main_control_pkg.sv
// Shared types and constants for the multicycle main control FSM.
// ADDI_EN adds the addi execute/writeback states; the encodings exist in both builds.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ILLEGAL   = 4'd11,
    S_ADDI_EXEC = 4'd12,
    S_ADDI_WB   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_out_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Bundle between the main control FSM (master) and the datapath/memory (slave).
interface multicycle_main_control_if #(
  parameter int INSTR_CNT_W = 16
);
  // Memory handshake: mem_read/mem_write are requests held steady by the FSM;
  // a transfer completes in any cycle where a request is high and mem_ready is 1.
  // mem_ready is ignored when no request is raised.
  logic [5:0]             opcode;
  logic                   mem_ready;
  logic                   pc_write;
  logic                   pc_write_cond;
  logic                   i_or_d;
  logic                   mem_read;
  logic                   mem_write;
  logic                   ir_write;
  logic                   mem_to_reg;
  logic                   reg_dst;
  logic                   reg_write;
  logic                   alu_src_a;
  logic [1:0]             alu_src_b;
  logic [1:0]             alu_op;
  logic [1:0]             pc_source;
  logic                   illegal;
  logic [INSTR_CNT_W-1:0] instr_retired;
  logic [3:0]             state_dbg;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal, instr_retired, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal, instr_retired, state_dbg
  );
endinterface

// File: rtl/multicycle_main_control_out_decode.sv
// Combinational state-to-strobe decoder; Moore except FETCH's ir_write/pc_write.
// ADDI_EN adds decode of the addi execute/writeback states.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_t    state,
  input  logic      mem_ready,
  output ctrl_out_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC+4 commit only on the cycle the instruction word arrives
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef ADDI_EN
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS-subset main control: state register, dispatch, retire counter, illegal flag.
// Defining ADDI_EN adds addi (opcode 0x08) support; otherwise 0x08 traps as illegal.
module multicycle_main_control
  import ctrl_pkg::*;
#(
  parameter int INSTR_CNT_W = 16
) (
  input logic                       clock,
  input logic                       reset_n,
  multicycle_main_control_if.master bus
);

  state_t                 state;
  state_t                 state_next;
  logic                   retire;
  logic                   illegal_q;
  logic [INSTR_CNT_W-1:0] retired_q;
  ctrl_out_t              ctrl;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (retire) retired_q <= retired_q + INSTR_CNT_W'(1);
      if (state_next == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_R_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
`ifdef ADDI_EN
          OP_ADDI:      state_next = S_ADDI_EXEC;
`else
          OP_ADDI:      state_next = S_ILLEGAL;
`endif
          default:      state_next = S_ILLEGAL;
        endcase
      end
      // Opcode is held stable past FETCH, so only lw/sw can reach here
      S_MEM_ADDR: state_next = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: if (bus.mem_ready) state_next = S_MEM_WB;
      S_MEM_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_R_EXEC: state_next = S_R_WB;
      S_R_WB, S_BRANCH, S_JUMP: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_ILLEGAL: state_next = S_ILLEGAL;
`ifdef ADDI_EN
      S_ADDI_EXEC: state_next = S_ADDI_WB;
      S_ADDI_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  ctrl_out_decode u_out_decode (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal       = illegal_q;
  assign bus.instr_retired = retired_q;
  assign bus.state_dbg     = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control with a 2-bit retire counter.
// Expected state/strobe sequences are queued per instruction and checked cycle by cycle.
module tb_multicycle_main_control;
  import ctrl_pkg::*;

  logic clock;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  logic [3:0] exp_q[$];
  logic       rdy_q[$];

  multicycle_main_control_if #(.INSTR_CNT_W(2)) bus ();

  multicycle_main_control #(.INSTR_CNT_W(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit order: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]
  function automatic logic [15:0] got_strobes();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source};
  endfunction

  function automatic logic [15:0] model(input logic [3:0] st, input logic r);
    logic [15:0] v;
    v = '0;
    case (st)
      S_FETCH:     begin v[12] = 1'b1; v[5:4] = 2'b01; v[10] = r; v[15] = r; end
      S_DECODE:    v[5:4] = 2'b11;
      S_MEM_ADDR:  begin v[6] = 1'b1; v[5:4] = 2'b10; end
      S_MEM_READ:  begin v[12] = 1'b1; v[13] = 1'b1; end
      S_MEM_WB:    begin v[7] = 1'b1; v[9] = 1'b1; end
      S_MEM_WRITE: begin v[11] = 1'b1; v[13] = 1'b1; end
      S_R_EXEC:    begin v[6] = 1'b1; v[3:2] = 2'b10; end
      S_R_WB:      begin v[7] = 1'b1; v[8] = 1'b1; end
      S_BRANCH:    begin v[6] = 1'b1; v[3:2] = 2'b01; v[14] = 1'b1; v[1:0] = 2'b01; end
      S_JUMP:      begin v[15] = 1'b1; v[1:0] = 2'b10; end
      S_ADDI_EXEC: begin v[6] = 1'b1; v[5:4] = 2'b10; end
      S_ADDI_WB:   v[7] = 1'b1;
      default:     v = '0;
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic push(input logic [3:0] st, input logic r);
    exp_q.push_back(st);
    rdy_q.push_back(r);
  endtask

  task automatic run_seq(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      logic [3:0] es;
      logic       r;
      es = exp_q.pop_front();
      r  = rdy_q.pop_front();
      bus.mem_ready = r;
      #1;
      check($sformatf("%s.st%0d", tag, i), 32'(bus.state_dbg), 32'(es));
      check($sformatf("%s.out%0d", tag, i), 32'(got_strobes()), 32'(model(es, r)));
      check($sformatf("%s.ill%0d", tag, i), 32'(bus.illegal), 32'(es == S_ILLEGAL));
      next_cycle();
    end
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    next_cycle();
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] j_ret[5];

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    j_ret         = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset_n       = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'h23;

    // Reset held with mem_ready high
    @(negedge clock);
    next_cycle();
    #1;
    check("rst.st", 32'(bus.state_dbg), 32'(S_IDLE));
    check("rst.out", 32'(got_strobes()), 32'h0);
    check("rst.ret", 32'(bus.instr_retired), 32'h0);
    check("rst.ill", 32'(bus.illegal), 32'h0);
    next_cycle();
    reset_n = 1'b1;

    // lw: 2 fetch waits, 1 read wait -> 8 cycles
    push(S_IDLE, 1'b1);
    push(S_FETCH, 1'b0); push(S_FETCH, 1'b0); push(S_FETCH, 1'b1);
    push(S_DECODE, 1'b0); push(S_MEM_ADDR, 1'b0);
    push(S_MEM_READ, 1'b0); push(S_MEM_READ, 1'b1); push(S_MEM_WB, 1'b0);
    run_seq("lw");
    #1 check("lw.ret", 32'(bus.instr_retired), 32'd1);

    bus.opcode = 6'h00;
    push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_R_EXEC, 1'b0); push(S_R_WB, 1'b1);
    run_seq("rtype");
    #1 check("rtype.ret", 32'(bus.instr_retired), 32'd2);

    bus.opcode = 6'h04;
    push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_BRANCH, 1'b1);
    run_seq("beq");
    #1 check("beq.ret", 32'(bus.instr_retired), 32'd3);

    bus.opcode = 6'h2B;
    push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_MEM_ADDR, 1'b1);
    push(S_MEM_WRITE, 1'b0); push(S_MEM_WRITE, 1'b1);
    run_seq("sw");
    #1 check("sw.ret_wrap", 32'(bus.instr_retired), 32'd0);

    // Five jumps: counter wraps 1,2,3,0,1
    for (int k = 0; k < 5; k++) begin
      bus.opcode = 6'h02;
      push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_JUMP, 1'b0);
      run_seq($sformatf("j%0d", k));
      #1 check($sformatf("j%0d.ret", k), 32'(bus.instr_retired), 32'(j_ret[k]));
    end

    // Reset while a store is stalled
    bus.opcode = 6'h2B;
    push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_MEM_ADDR, 1'b1);
    push(S_MEM_WRITE, 1'b0); push(S_MEM_WRITE, 1'b0);
    run_seq("swrst");
    bus.mem_ready = 1'b0;
    #1;
    check("swrst.mw_before", 32'(bus.mem_write), 32'd1);
    check("swrst.noret", 32'(bus.instr_retired), 32'd1);
    reset_n = 1'b0;
    #1;
    check("swrst.mw_after", 32'(bus.mem_write), 32'd0);
    check("swrst.out", 32'(got_strobes()), 32'h0);
    check("swrst.st", 32'(bus.state_dbg), 32'(S_IDLE));
    check("swrst.ret", 32'(bus.instr_retired), 32'd0);
    next_cycle();
    reset_n = 1'b1;

    // Opcode 0x08: addi when enabled, illegal otherwise
    bus.opcode = 6'h08;
    push(S_IDLE, 1'b1); push(S_FETCH, 1'b1); push(S_DECODE, 1'b1);
`ifdef ADDI_EN
    push(S_ADDI_EXEC, 1'b0); push(S_ADDI_WB, 1'b1);
    run_seq("addi");
    #1;
    check("addi.ret", 32'(bus.instr_retired), 32'd1);
    check("addi.st", 32'(bus.state_dbg), 32'(S_FETCH));
`else
    push(S_ILLEGAL, 1'b1);
    run_seq("addi_off");
    #1;
    check("addi_off.ill", 32'(bus.illegal), 32'd1);
    check("addi_off.ret", 32'(bus.instr_retired), 32'd0);
`endif
    reset_pulse();

    // Illegal opcode: trapped and held for 20 cycles
    bus.opcode = 6'h3F;
    push(S_IDLE, 1'b1); push(S_FETCH, 1'b1); push(S_DECODE, 1'b0);
    for (int k = 0; k < 20; k++) push(S_ILLEGAL, 1'($urandom_range(0, 1)));
    run_seq("illegal");
    #1 check("illegal.ret", 32'(bus.instr_retired), 32'd0);
    reset_n = 1'b0;
    #1;
    check("illegal.clr", 32'(bus.illegal), 32'd0);
    check("illegal.clr_st", 32'(bus.state_dbg), 32'(S_IDLE));
    next_cycle();
    reset_n = 1'b1;

    // Normal operation resumes after the trap is cleared
    bus.opcode = 6'h02;
    push(S_IDLE, 1'b1); push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_JUMP, 1'b1);
    run_seq("resume");
    #1 check("resume.ret", 32'(bus.instr_retired), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
